// File: rtl/fc_feeder.sv
// Sequencer for the fully-connected front end: streams activation/weight words
// per neuron, supplies the bias, collects the datapath result and writes it back.
module fc_feeder #(
    parameter int DW      = 64,
    parameter int BW      = 25,
    parameter int RW      = 21,
    parameter int WORDS   = 64,
    parameter int NA_W    = 6,
    parameter int TIMEOUT = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NA_W:0]                    num_neurons,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic                             d_ren,
    output logic [$clog2(WORDS)-1:0]         d_raddr,
    input  logic [DW-1:0]                    d_rdata,
    output logic                             w_ren,
    output logic [NA_W+$clog2(WORDS)-1:0]    w_raddr,
    input  logic [DW-1:0]                    w_rdata,
    output logic                             b_ren,
    output logic [NA_W-1:0]                  b_raddr,
    input  logic [BW-1:0]                    b_rdata,
    output logic                             fc_vld,
    output logic [DW-1:0]                    fc_d,
    output logic [DW-1:0]                    fc_w,
    output logic [BW-1:0]                    fc_bias,
    input  logic [RW-1:0]                    fc_result,
    input  logic                             fc_cyc_done,
    output logic                             r_wen,
    output logic [NA_W-1:0]                  r_waddr,
    output logic [RW-1:0]                    r_wdata
);

    localparam int KW = $clog2(WORDS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [KW-1:0]   K_ONE    = KW'(1);
    localparam logic [KW-1:0]   K_LAST   = KW'(WORDS - 1);
    localparam logic [TW-1:0]   TMO_ONE  = TW'(1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [NA_W:0]   NUM_ZERO = {(NA_W+1){1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [KW-1:0]     k_r;
    logic [NA_W-1:0]   n_r;
    logic [NA_W:0]     num_r;
    logic [NA_W:0]     n_inc_s;
    logic [TW-1:0]     tmo_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic              r_wen_r;
    logic [NA_W-1:0]   r_waddr_r;
    logic [RW-1:0]     r_wdata_r;
    logic              fc_vld_r;
    logic              b_vld_r;
    logic [BW-1:0]     fc_bias_r;
    logic              d_ren_s;
    logic              b_ren_s;
    logic [KW-1:0]     d_raddr_s;
    logic [NA_W-1:0]   b_raddr_s;

    assign n_inc_s = {1'b0, n_r} + {{NA_W{1'b0}}, 1'b1};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = (num_neurons == NUM_ZERO) ? ST_FIN : ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (k_r == K_LAST) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (fc_cyc_done) begin
                    state_s = ST_WRITE;
                end else if (tmo_r == TMO_LAST) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WRITE: begin
                if (n_inc_s == num_r) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Read-side outputs track the ISSUE state directly so reads are back-to-back
    always_comb begin
        d_ren_s   = 1'b0;
        b_ren_s   = 1'b0;
        d_raddr_s = {KW{1'b0}};
        b_raddr_s = {NA_W{1'b0}};
        if (state_r == ST_ISSUE) begin
            d_ren_s   = 1'b1;
            b_ren_s   = (k_r == {KW{1'b0}});
            d_raddr_s = k_r;
            b_raddr_s = n_r;
        end else begin
            d_ren_s   = 1'b0;
            b_ren_s   = 1'b0;
        end
    end

    // Counters, run status and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_r       <= {KW{1'b0}};
            n_r       <= {NA_W{1'b0}};
            num_r     <= NUM_ZERO;
            tmo_r     <= {TW{1'b0}};
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
            r_wdata_r <= {RW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        num_r  <= num_neurons;
                        err_r  <= 1'b0;
                        busy_r <= 1'b1;
                        n_r    <= {NA_W{1'b0}};
                        k_r    <= {KW{1'b0}};
                    end
                end
                ST_ISSUE: begin
                    k_r   <= (k_r == K_LAST) ? {KW{1'b0}} : k_r + K_ONE;
                    tmo_r <= {TW{1'b0}};
                    if (fc_cyc_done) begin
                        err_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (fc_cyc_done) begin
                        r_wdata_r <= fc_result;
                    end else if (tmo_r == TMO_LAST) begin
                        err_r <= 1'b1;
                    end else begin
                        tmo_r <= tmo_r + TMO_ONE;
                    end
                end
                ST_WRITE: begin
                    n_r <= n_inc_s[NA_W-1:0];
                    if (fc_cyc_done) begin
                        err_r <= 1'b1;
                    end
                end
                ST_FIN:  busy_r <= 1'b0;
                default: busy_r <= 1'b0;
            endcase
        end
    end

    // Write strobe and done follow their states by one registered cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_r    <= 1'b0;
            r_wen_r   <= 1'b0;
            r_waddr_r <= {NA_W{1'b0}};
            fc_vld_r  <= 1'b0;
            b_vld_r   <= 1'b0;
            fc_bias_r <= {BW{1'b0}};
        end else begin
            done_r   <= (state_r == ST_FIN);
            r_wen_r  <= (state_r == ST_WRITE);
            fc_vld_r <= d_ren_s;
            b_vld_r  <= b_ren_s;
            if (state_r == ST_WRITE) begin
                r_waddr_r <= n_r;
            end
            if (b_vld_r) begin
                fc_bias_r <= b_rdata;
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;
    assign d_ren   = d_ren_s;
    assign w_ren   = d_ren_s;
    assign d_raddr = d_raddr_s;
    assign w_raddr = d_ren_s ? {n_r, k_r} : {(NA_W+KW){1'b0}};
    assign b_ren   = b_ren_s;
    assign b_raddr = b_raddr_s;
    assign fc_vld  = fc_vld_r;
    assign fc_d    = rst ? {DW{1'b0}} : d_rdata;
    assign fc_w    = rst ? {DW{1'b0}} : w_rdata;
    assign fc_bias = fc_bias_r;
    assign r_wen   = r_wen_r;
    assign r_waddr = r_waddr_r;
    assign r_wdata = r_wdata_r;

endmodule

// File: tb/tb_fc_feeder.sv
// Scoreboard bench for fc_feeder: buffer and datapath models around the DUT,
// expected reads/writes/done queued by stimulus and popped by a monitor.
module tb_fc_feeder;

    localparam int DW    = 64;
    localparam int BW    = 25;
    localparam int RW    = 21;
    localparam int WORDS = 64;
    localparam int NA_W  = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [NA_W:0]     num_neurons = 7'd0;
    logic              busy, done, err;
    logic              d_ren, w_ren, b_ren;
    logic [5:0]        d_raddr;
    logic [11:0]       w_raddr;
    logic [5:0]        b_raddr;
    logic [DW-1:0]     d_rdata = 64'd0;
    logic [DW-1:0]     w_rdata = 64'd0;
    logic [BW-1:0]     b_rdata = 25'd0;
    logic              fc_vld;
    logic [DW-1:0]     fc_d, fc_w;
    logic [BW-1:0]     fc_bias;
    logic [RW-1:0]     fc_result = 21'd0;
    logic              fc_cyc_done;
    logic              dp_done = 1'b0;
    logic              spur = 1'b0;
    logic              r_wen;
    logic [NA_W-1:0]   r_waddr;
    logic [RW-1:0]     r_wdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_dren = 0;
    bit dp_respond = 1'b1;

    logic [17:0] addr_q[$];
    logic [5:0]  b_q[$];
    logic [26:0] r_q[$];
    bit          done_q[$];

    assign fc_cyc_done = dp_done | spur;

    fc_feeder dut (
        .clk(clk), .rst(rst), .start(start), .num_neurons(num_neurons),
        .busy(busy), .done(done), .err(err),
        .d_ren(d_ren), .d_raddr(d_raddr), .d_rdata(d_rdata),
        .w_ren(w_ren), .w_raddr(w_raddr), .w_rdata(w_rdata),
        .b_ren(b_ren), .b_raddr(b_raddr), .b_rdata(b_rdata),
        .fc_vld(fc_vld), .fc_d(fc_d), .fc_w(fc_w), .fc_bias(fc_bias),
        .fc_result(fc_result), .fc_cyc_done(fc_cyc_done),
        .r_wen(r_wen), .r_waddr(r_waddr), .r_wdata(r_wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Weight byte of neuron n is 2*(n+1); activations are all 0x01
    function automatic logic [7:0] wbyte(input logic [11:0] a);
        return 8'(2 * (int'(a[11:6]) + 1));
    endfunction

    function automatic logic [BW-1:0] bias_of(input logic [5:0] a);
        case (a)
            6'd0:    return 25'd5;
            6'd1:    return 25'd15;
            6'd2:    return BW'(-5000);
            default: return 25'd0;
        endcase
    endfunction

    // Hand-computed: 512 products of 1*(2*(n+1)) plus bias
    function automatic logic [RW-1:0] exp_res(input int n);
        case (n)
            0:       return 21'd1029;
            1:       return 21'd2063;
            default: return RW'(-1928);
        endcase
    endfunction

    function automatic int dot(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int s = 0;
        for (int i = 0; i < 8; i++) s += int'($signed(a[i*8 +: 8])) * int'($signed(b[i*8 +: 8]));
        return s;
    endfunction

    // Synchronous-read buffers
    always @(posedge clk) begin
        if (d_ren) d_rdata <= {8{8'h01}};
        if (w_ren) w_rdata <= {8{wbyte(w_raddr)}};
        if (b_ren) b_rdata <= bias_of(b_raddr);
    end

    // Datapath model: accumulate 64 words, answer 4 cycles after the last one
    int dp_cnt = 0;
    int dp_dly = 0;
    int dp_acc = 0;
    always @(posedge clk) begin
        if (rst) begin
            dp_cnt  <= 0;
            dp_dly  <= 0;
            dp_acc  <= 0;
            dp_done <= 1'b0;
        end else begin
            dp_done <= 1'b0;
            if (fc_vld) begin
                dp_acc <= ((dp_cnt == 0) ? 0 : dp_acc) + dot(fc_d, fc_w);
                if (dp_cnt == WORDS - 1) begin
                    dp_cnt <= 0;
                    if (dp_respond) dp_dly <= 4;
                end else begin
                    dp_cnt <= dp_cnt + 1;
                end
            end
            if (dp_dly > 0) begin
                dp_dly <= dp_dly - 1;
                if (dp_dly == 1) begin
                    dp_done   <= 1'b1;
                    fc_result <= RW'(dp_acc + int'($signed(fc_bias)));
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic unexp(input string name, input logic [63:0] got);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event, value 0x%0h, expected none", name, got);
    endtask

    // Monitor: pops expectations whenever the DUT presents an event
    initial begin
        int run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else begin
                if (d_ren) begin
                    last_dren = cyc;
                    chk("w_ren", {63'd0, w_ren}, 64'd1);
                    if (addr_q.size() == 0) unexp("rd_addr", {46'd0, d_raddr, w_raddr});
                    else chk("rd_addr", {46'd0, d_raddr, w_raddr}, {46'd0, addr_q.pop_front()});
                end
                if (b_ren) begin
                    if (b_q.size() == 0) unexp("b_raddr", {58'd0, b_raddr});
                    else chk("b_raddr", {58'd0, b_raddr}, {58'd0, b_q.pop_front()});
                end
                if (r_wen) begin
                    if (r_q.size() == 0) unexp("r_write", {37'd0, r_waddr, r_wdata});
                    else chk("r_write", {37'd0, r_waddr, r_wdata}, {37'd0, r_q.pop_front()});
                end
                if (done) begin
                    chk("done_busy", {63'd0, busy}, 64'd0);
                    if (done_q.size() == 0) unexp("done", {63'd0, err});
                    else chk("done_err", {63'd0, err}, {63'd0, done_q.pop_front()});
                end
                if (fc_vld) begin
                    run++;
                end else if (run != 0) begin
                    chk("vld_run", 64'(run), 64'd64);
                    run = 0;
                end
            end
        end
    end

    task automatic push_neuron(input int n, input bit with_write);
        for (int k = 0; k < WORDS; k++) addr_q.push_back({6'(k), 12'(n * WORDS + k)});
        b_q.push_back(6'(n));
        if (with_write) r_q.push_back({6'(n), exp_res(n)});
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) unexp("done_timeout", 64'd0);
    endtask

    // mode 0: normal, 1: datapath never answers, 2: start re-pulse + spurious done
    task automatic run(input int num, input int mode);
        for (int n = 0; n < ((mode == 1) ? 1 : num); n++) push_neuron(n, mode != 1);
        done_q.push_back(mode != 0);
        dp_respond = (mode != 1);
        @(negedge clk);
        num_neurons = 7'(num);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("accept_busy", {63'd0, busy}, 64'd1);
        chk("accept_err_clear", {63'd0, err}, 64'd0);
        if (mode == 2) begin
            repeat (10) @(negedge clk);
            start = 1'b1;
            spur  = 1'b1;
            @(negedge clk);
            start = 1'b0;
            spur  = 1'b0;
        end
        wait_done();
        if (mode == 1) chk("tmo_latency", 64'(cyc - last_dren), 64'd257);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_queues_empty(input string tag);
        chk({tag, "_addr_q"}, 64'(addr_q.size()), 64'd0);
        chk({tag, "_b_q"}, 64'(b_q.size()), 64'd0);
        chk({tag, "_r_q"}, 64'(r_q.size()), 64'd0);
        chk({tag, "_done_q"}, 64'(done_q.size()), 64'd0);
    endtask

    initial begin
        bit hit = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {56'd0, busy, done, err, d_ren, w_ren, b_ren, fc_vld, r_wen}, 64'd0);
        chk("reset_res", {18'd0, fc_bias, r_wdata}, 64'd0);
        rst = 1'b0;

        run(1, 0);
        run(3, 0);

        // Zero neurons, start held into the FIN cycle
        done_q.push_back(1'b0);
        @(negedge clk);
        num_neurons = 7'd0;
        start = 1'b1;
        @(negedge clk);
        chk("zero_busy", {63'd0, busy}, 64'd1);
        chk("zero_done_early", {63'd0, done}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", {63'd0, done}, 64'd1);
        @(negedge clk);
        chk("zero_done_pulse", {63'd0, done}, 64'd0);
        repeat (5) @(negedge clk);

        run(2, 1);
        run(1, 0);

        // Abort with reset at k=30 of neuron 1
        push_neuron(0, 1'b1);
        for (int k = 0; k <= 30; k++) addr_q.push_back({6'(k), 12'(WORDS + k)});
        b_q.push_back(6'd1);
        dp_respond = 1'b1;
        @(negedge clk);
        num_neurons = 7'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            hit = d_ren && (w_raddr == 12'd94);
        end
        if (!hit) unexp("abort_point_timeout", 64'd0);
        #1 rst = 1'b1;
        #1;
        chk("rst_ctrl", {56'd0, busy, done, err, d_ren, w_ren, b_ren, fc_vld, r_wen}, 64'd0);
        chk("rst_addr", {34'd0, d_raddr, w_raddr, b_raddr, r_waddr}, 64'd0);
        chk("rst_data", fc_d | fc_w, 64'd0);
        chk("rst_res", {18'd0, fc_bias, r_wdata}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_queues_empty("abort");

        run(1, 0);
        run(2, 2);

        repeat (10) @(negedge clk);
        chk_queues_empty("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, expected run to complete");
        $fatal(1, "watchdog expired");
    end

endmodule
